// File: rtl/ocm_dp_ctrl.sv
// ocm_dp_ctrl: parametrised dual-port on-chip memory with per-port
// request/ready/valid handshakes, RD_LAT of 1 or 2, and write/write collision
// resolution where port A wins. The background clear engine is built only when
// the OCM_CLEAR_EN macro is defined. Otherwise BUSY is tied to 0 and READY is
// tied to 1.
module ocm_dp_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              MAIN_CLK,
  input  logic              RESET,
  input  logic              OCM_REQ_A,
  input  logic              OCM_REQ_B,
  input  logic              OCM_WE_A,
  input  logic              OCM_WE_B,
  input  logic [ADDR_W-1:0] OCM_ADDR_A,
  input  logic [ADDR_W-1:0] OCM_ADDR_B,
  input  logic [DATA_W-1:0] OCM_DATAIN_A,
  input  logic [DATA_W-1:0] OCM_DATAIN_B,
  output logic              OCM_READY_A,
  output logic              OCM_READY_B,
  output logic [DATA_W-1:0] OCM_DATAOUT_A,
  output logic [DATA_W-1:0] OCM_DATAOUT_B,
  output logic              OCM_VALID_A,
  output logic              OCM_VALID_B,
  input  logic              OCM_CLEAR,
  input  logic [DATA_W-1:0] OCM_CLEAR_VAL,
  output logic              OCM_BUSY,
  output logic              OCM_COLLIDE
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_acc_a, w_acc_b;
  logic              w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic              w_collide;
  logic [DATA_W-1:0] w_rdata_a, w_rdata_b;
  logic              w_fill_we;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data;

  logic              r_collide;
  logic [DATA_W-1:0] r_dout_a, r_dout_b;
  logic              r_valid_a, r_valid_b;

  assign w_acc_a   = OCM_REQ_A & OCM_READY_A;
  assign w_acc_b   = OCM_REQ_B & OCM_READY_B;
  assign w_wr_a    = w_acc_a & OCM_WE_A;
  assign w_wr_b    = w_acc_b & OCM_WE_B;
  assign w_rd_a    = w_acc_a & ~OCM_WE_A;
  assign w_rd_b    = w_acc_b & ~OCM_WE_B;
  assign w_collide = w_wr_a & w_wr_b & (OCM_ADDR_A == OCM_ADDR_B);

  // Array read ahead of the edge sees pre-write contents, which gives read-first behaviour
  assign w_rdata_a = r_mem[OCM_ADDR_A];
  assign w_rdata_b = r_mem[OCM_ADDR_B];

  // RAM write port: clear fill, then B, then A; a B write that collides with A is dropped
  always_ff @(posedge MAIN_CLK) begin
    if (w_fill_we) begin
      r_mem[w_fill_addr] <= w_fill_data;
    end
    if (w_wr_b && !w_collide) begin
      r_mem[OCM_ADDR_B] <= OCM_DATAIN_B;
    end
    if (w_wr_a) begin
      r_mem[OCM_ADDR_A] <= OCM_DATAIN_A;
    end
  end

  // Collision flag: a one-cycle pulse after the colliding edge
  always_ff @(posedge MAIN_CLK or posedge RESET) begin
    if (RESET) begin
      r_collide <= 1'b0;
    end else begin
      r_collide <= w_collide;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_s1_a, r_s1_b;
      logic              r_s1_va, r_s1_vb;

      // Two-stage read return; the extra output register keeps one read per cycle per port
      always_ff @(posedge MAIN_CLK or posedge RESET) begin
        if (RESET) begin
          r_s1_a    <= '0;
          r_s1_b    <= '0;
          r_s1_va   <= 1'b0;
          r_s1_vb   <= 1'b0;
          r_dout_a  <= '0;
          r_dout_b  <= '0;
          r_valid_a <= 1'b0;
          r_valid_b <= 1'b0;
        end else begin
          r_s1_va   <= w_rd_a;
          r_s1_vb   <= w_rd_b;
          if (w_rd_a) r_s1_a <= w_rdata_a;
          if (w_rd_b) r_s1_b <= w_rdata_b;
          r_valid_a <= r_s1_va;
          r_valid_b <= r_s1_vb;
          if (r_s1_va) r_dout_a <= r_s1_a;
          if (r_s1_vb) r_dout_b <= r_s1_b;
        end
      end
    end else begin : g_lat1
      // Single-stage read return; DATAOUT holds its value between reads
      always_ff @(posedge MAIN_CLK or posedge RESET) begin
        if (RESET) begin
          r_dout_a  <= '0;
          r_dout_b  <= '0;
          r_valid_a <= 1'b0;
          r_valid_b <= 1'b0;
        end else begin
          r_valid_a <= w_rd_a;
          r_valid_b <= w_rd_b;
          if (w_rd_a) r_dout_a <= w_rdata_a;
          if (w_rd_b) r_dout_b <= w_rdata_b;
        end
      end
    end
  endgenerate

`ifdef OCM_CLEAR_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_fill_val, w_fill_val_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_ready, w_ready_nxt;

  // Clear FSM state, counter, latched fill value and the registered READY/BUSY outputs
  always_ff @(posedge MAIN_CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_fill_val <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fill_val <= w_fill_val_nxt;
      r_busy     <= w_busy_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // Next state: a clear fills words 0..DEPTH-1 one per cycle, then returns to IDLE
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fill_val_nxt = r_fill_val;
    w_fill_we      = 1'b0;
    w_fill_addr    = r_cnt[ADDR_W-1:0];
    w_fill_data    = r_fill_val;
    case (r_state)
      ST_IDLE: begin
        if (OCM_CLEAR) begin
          w_state_nxt    = ST_CLEAR;
          w_cnt_nxt      = '0;
          w_fill_val_nxt = OCM_CLEAR_VAL;
        end
      end
      ST_CLEAR: begin
        w_fill_we = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt  = (w_state_nxt == ST_CLEAR);
    w_ready_nxt = ~w_busy_nxt;
  end

  assign OCM_BUSY    = r_busy;
  assign OCM_READY_A = r_ready;
  assign OCM_READY_B = r_ready;
`else
  logic w_unused_clear;

  // Clear engine absent: ports are always ready and the clear inputs are ignored
  assign w_unused_clear = ^{OCM_CLEAR, OCM_CLEAR_VAL};
  assign w_fill_we      = 1'b0;
  assign w_fill_addr    = '0;
  assign w_fill_data    = '0;
  assign OCM_BUSY       = 1'b0;
  assign OCM_READY_A    = 1'b1;
  assign OCM_READY_B    = 1'b1;
`endif

  assign OCM_COLLIDE   = r_collide;
  assign OCM_DATAOUT_A = r_dout_a;
  assign OCM_DATAOUT_B = r_dout_b;
  assign OCM_VALID_A   = r_valid_a;
  assign OCM_VALID_B   = r_valid_b;

endmodule

// File: doc/ocm_dp_ctrl.md
# ocm_dp_ctrl

Parametrised dual-port on-chip memory with per-port request/ready/valid handshakes, selectable read latency, deterministic collision handling and a background clear engine. It is the successor to the fixed 16×64K dual-port OCM and sits between the ray-tracer pipeline clients (ports A and B) and the on-chip RAM. It lets clients stall safely while the framebuffer or scene memory is being cleared.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 16, address width; DEPTH = 2**ADDR_W words
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only

Ports:
- MAIN_CLK  in  1  sole clock; all logic updates on its rising edge
- RESET  in  1  asynchronous, active-high reset
- OCM_REQ_A / OCM_REQ_B  in  1  access request, one per port
- OCM_WE_A / OCM_WE_B  in  1  1 = write, 0 = read; qualified by REQ
- OCM_ADDR_A / OCM_ADDR_B  in  ADDR_W  word address
- OCM_DATAIN_A / OCM_DATAIN_B  in  DATA_W  write data
- OCM_READY_A / OCM_READY_B  out  1  port can accept a request this cycle
- OCM_DATAOUT_A / OCM_DATAOUT_B  out  DATA_W  read data; holds its last value between reads
- OCM_VALID_A / OCM_VALID_B  out  1  one-cycle pulse marking fresh read data
- OCM_CLEAR  in  1  start a clear of the whole memory
- OCM_CLEAR_VAL  in  DATA_W  fill value; sampled on the accepting edge
- OCM_BUSY  out  1  clear in progress
- OCM_COLLIDE  out  1  one-cycle pulse on a same-address write/write collision

## Operation
- A request is accepted on a rising edge where REQ_x=1 and READY_x=1. A request with READY_x=0 is ignored, not queued.
- Accepted write: the word is written at that edge. No VALID is produced.
- Accepted read: returns the word's value from before that edge's writes (read-first). This holds for writes on the same port and on the other port.
- Write/write to the same address in the same cycle: port A's data is stored and port B's is dropped. OCM_COLLIDE pulses for one cycle.
- Read/write and read/read to the same address across the two ports are legal, with no flag.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR: on an edge with OCM_CLEAR=1. CLEAR_VAL is latched, the counter is set to 0, and port requests sampled on that same edge are still accepted.
  - In CLEAR: one word per cycle is written with the latched value, at addresses 0..DEPTH-1 in order.
  - CLEAR→IDLE: after the write to DEPTH-1.
  - OCM_CLEAR while in CLEAR is ignored.
- READY_A = READY_B = 1 in IDLE and 0 in CLEAR. BUSY = 1 exactly in CLEAR. Both READY and BUSY are registered.
- Reads accepted before a clear starts still complete, with VALID at normal latency.
- Reset values:
  - READY_A/B = 1; DATAOUT_A/B = 0; VALID_A/B = 0; BUSY = 0; COLLIDE = 0; FSM = IDLE; counter = 0.
  - In-flight reads are dropped.
  - RAM contents are not reset.
- Reset during CLEAR aborts it. Words already written keep the fill value; the rest are unchanged.
- Address arithmetic is unsigned ADDR_W. The clear counter is ADDR_W+1 bits so it can detect terminal DEPTH-1 without wrapping.

## Timing
- RD_LAT=1: a read accepted at edge k drives DATAOUT and VALID=1 after edge k, for one cycle.
- RD_LAT=2: the same read gives DATAOUT and VALID after edge k+1. The output register is extra; throughput is unchanged.
- Throughput is one accepted request per port per cycle, so back-to-back reads give continuous VALID.
- CLEAR accepted at edge k: BUSY=1 and READY=0 after edge k. The first fill write is at edge k+1 and the last at edge k+DEPTH. BUSY=0 and READY=1 after edge k+DEPTH.
- COLLIDE is asserted after the colliding edge, for one cycle.

## Configuration
- Macro: OCM_CLEAR_EN.
- Defined: the clear FSM, OCM_BUSY and READY deassertion are implemented as described above.
- Undefined:
  - No FSM or counter is built. OCM_CLEAR and OCM_CLEAR_VAL are ignored.
  - OCM_BUSY is tied to 0, and READY_A/B are tied to 1, including during reset.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read check: with RESET held, READY_A/B=1, VALID=0, DATAOUT=0, BUSY=0. After release, write 0x1234 to A@0x0005, then read B@0x0005 → VALID_B pulses with 0x1234 after 1 edge (RD_LAT=1) and after 2 edges (RD_LAT=2).
- Write/write collision: A writes 0xAAAA and B writes 0x5555 to 0x0010 on the same edge → COLLIDE pulses once; a later read returns 0xAAAA.
- Read-first across ports: word 0x0020 holds 0x0001. A writes 0x00FF to it while B reads it on the same edge → B returns 0x0001; the next read returns 0x00FF.
- Clear, with ADDR_W=4 and OCM_CLEAR_EN defined: pulse OCM_CLEAR with CLEAR_VAL=0xBEEF, together with A reading 0x3 → the read completes normally. BUSY and READY=0 last exactly 16 cycles. A REQ_B held high during the clear is ignored. Afterwards, reads of all 16 words return 0xBEEF.
- Reset mid-clear, with ADDR_W=4: memory is prefilled with 0x0000. Clear with 0xFFFF, then assert RESET after the 6th fill write → words 0–5 read 0xFFFF, words 6–15 read 0x0000, and BUSY=0.
- Build without OCM_CLEAR_EN: pulse OCM_CLEAR → BUSY stays 0, READY stays 1, and back-to-back reads continue to produce VALID every cycle.
